// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a 3-input mux select with a bounded slot length and registered data output.
// Define MUX_SCHED_ERR_CHECK_EN to add the sticky err output that watches the sel/gnt invariants.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no owner; gnt=0, sel holds its last legal code
// S_SLOT | one requester owns the mux; slot counter runs toward expiry
module mux_rr_scheduler #(
    parameter int N_REQ       = 3,
    parameter int SLOT_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [1:0]       sel,
    output logic [N_REQ-1:0] gnt,
    output logic             y,
    output logic             y_valid,
    output logic             busy
`ifdef MUX_SCHED_ERR_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SLOT = 1'b1
    } state_t;

    function automatic logic [1:0] f_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [N_REQ-1:0] f_onehot(input logic [1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Returns {found, index} of the first set mask bit, scanning upward from start with wrap 2->0.
    function automatic logic [2:0] f_pick(input logic [N_REQ-1:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        idx = start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!res[2] && mask[idx]) begin
                res = {1'b1, idx};
            end
            idx = f_inc(idx);
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [CNT_W-1:0] w_slot_cnt_nxt;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       w_rr_ptr_nxt;
    logic             r_y;
    logic             r_y_valid;

    logic             w_owner_req;
    logic             w_expire;
    logic [N_REQ-1:0] w_mask;
    logic [1:0]       w_start;
    logic [2:0]       w_pick;
    logic             w_found;
    logic [1:0]       w_win;

    assign w_owner_req = req[r_sel];
    assign w_expire    = (r_slot_cnt == CNT_W'(SLOT_CYCLES - 1));

    // A releasing owner is masked out; an expiring owner stays eligible but is searched last.
    assign w_mask  = (r_state == S_SLOT && !w_owner_req) ? (req & ~f_onehot(r_sel)) : req;
    assign w_start = (r_state == S_SLOT) ? f_inc(r_sel) : r_rr_ptr;
    assign w_pick  = f_pick(w_mask, w_start);
    assign w_found = w_pick[2];
    assign w_win   = w_pick[1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_gnt_nxt      = r_gnt;
        w_slot_cnt_nxt = r_slot_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_SLOT;
                    w_sel_nxt      = w_win;
                    w_gnt_nxt      = f_onehot(w_win);
                    w_slot_cnt_nxt = '0;
                    w_rr_ptr_nxt   = f_inc(w_win);
                end
            end
            S_SLOT: begin
                if (!w_owner_req || w_expire) begin
                    if (w_found) begin
                        w_sel_nxt      = w_win;
                        w_gnt_nxt      = f_onehot(w_win);
                        w_slot_cnt_nxt = '0;
                        w_rr_ptr_nxt   = f_inc(w_win);
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_gnt_nxt      = '0;
                        w_slot_cnt_nxt = '0;
                    end
                end else begin
                    w_slot_cnt_nxt = r_slot_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_gnt_nxt      = '0;
                w_slot_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'b00;
            r_gnt      <= '0;
            r_slot_cnt <= '0;
            r_rr_ptr   <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_gnt      <= w_gnt_nxt;
            r_slot_cnt <= w_slot_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    // y only captures while someone is granted, so it holds its last data when y_valid drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
        end else begin
            if (r_gnt != '0) begin
                r_y <= din[r_sel];
            end
            r_y_valid <= (r_gnt != '0);
        end
    end

`ifdef MUX_SCHED_ERR_CHECK_EN
    logic r_err;
    logic w_err_cond;

    assign w_err_cond = (r_sel == 2'b11)
                     || ((r_gnt & (r_gnt - N_REQ'(1))) != '0)
                     || ((r_gnt != '0) && (r_gnt != f_onehot(r_sel)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_err_cond) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign sel     = r_sel;
    assign gnt     = r_gnt;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign busy    = (r_state == S_SLOT);

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares a 3-input, 2-bit-select mux among 3 requesters.
- Drives `sel` so the unmapped code 2'b11 is never produced; there is no latch-prone hold state.
- Registers the selected data bit with a valid flag.
- Sits directly in front of the mux datapath; replaces the free-running select counter.

Parameters:
- N_REQ, 3, number of requesters. Fixed at 3; sel codes 0..2 are legal.
- SLOT_CYCLES, 4, maximum consecutive cycles one requester may hold the grant (1..7).
- CNT_W, 3, width of the slot counter. Must hold SLOT_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  3  request per requester, level-sensitive.
- din  input  3  data bit per requester (mux inputs i0..i2).
- sel  output  2  mux select; only 2'b00, 2'b01, 2'b10 are ever driven.
- gnt  output  3  one-hot grant, or 3'b000 when idle.
- y  output  1  registered mux output, din[sel].
- y_valid  output  1  y holds data from a granted requester.
- busy  output  1  high while in SLOT state.

Behaviour:
- Reset: async assert when reset_n=0.
  - state=IDLE, sel=2'b00, gnt=3'b000, y=0, y_valid=0, busy=0, rr_ptr=0, slot_cnt=0.
  - Deassertion takes effect at the next clk edge.
- Arbitration: search starts at rr_ptr, i.e. the requester after the last winner, wrapping 2->0. The first asserted req wins.
- IDLE:
  - If any req=1 at an edge: go to SLOT, gnt=onehot(winner), sel=winner, slot_cnt=0, busy=1.
  - Otherwise hold; sel keeps its last legal value.
- SLOT, each edge:
  - If req[owner]=0: release. Rearbitrate in the same edge, excluding owner; IDLE if no other req.
  - Else if slot_cnt==SLOT_CYCLES-1: expiry. Rearbitrate from owner+1. If only owner requests, owner is regranted and slot_cnt restarts at 0.
  - Else slot_cnt++.
  - On every handover, rr_ptr=winner+1 mod 3.
- Switching: handover is back-to-back, with no idle cycle between owners. gnt changes on the same edge as sel.
- Latency:
  - gnt/sel appear 1 cycle after req is sampled.
  - y and y_valid lag sel by 1 cycle: y <= din[sel] and y_valid <= (gnt!=0) at each edge.
  - y keeps its last value when y_valid=0.
- Simultaneous requests, all three asserted from reset: grant order 0,1,2,0,... with SLOT_CYCLES cycles each.
- Mid-slot reset: everything returns to reset values immediately; the partial slot is discarded and rr_ptr returns to 0.
- Invariants:
  - gnt is one-hot or zero.
  - sel==index(gnt) whenever gnt!=0.
  - sel is never 2'b11, including after reset.
- Counter: slot_cnt is CNT_W bits, unsigned, and never wraps (it resets on every grant).

Optional Feature:
- Macro: MUX_SCHED_ERR_CHECK_EN.
- Defined:
  - Adds output err (1 bit), a sticky flag, cleared only by reset_n.
  - err sets on any edge where sel==2'b11, gnt is not one-hot-or-zero, or gnt!=0 with sel!=index(gnt).
  - The bench forces an internal fault to confirm detection.
- Undefined:
  - Port err is absent; no checking logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 for 10 ns with req=3'b111 -> sel=2'b00, gnt=3'b000, y_valid=0, busy=0 throughout. First grant gnt=3'b001 one edge after release.
- Fairness: req=3'b111 for 24 cycles, SLOT_CYCLES=4 -> gnt sequence 001×4, 010×4, 100×4, repeated twice. sel 0,1,2 only; never 2'b11.
- Early release: req=3'b011; at cycle 2 of owner 0, drop req[0] -> next edge gnt=3'b010 with slot_cnt=0. No idle gap; busy stays 1.
- Sole requester expiry: req=3'b100 for 10 cycles -> gnt=3'b100 continuously, slot_cnt restarts at 0 after cycles 4 and 8. Drop req -> IDLE, busy=0, sel stays 2'b10.
- Data path: gnt=3'b010, din toggling with period 74 ns on bit 1 -> y equals din[1] delayed one clock. y_valid=1 while granted and 0 the cycle after IDLE is entered.
- Mid-slot reset plus error check: assert reset_n=0 during owner 1's slot -> immediate reset values, then arbitration restarts at requester 0. With MUX_SCHED_ERR_CHECK_EN, forcing sel=2'b11 for one cycle -> err=1 until the next reset.
